// File: rtl/vend_core.sv
// vend_core: vending-machine transaction core tracking credit, holding vend/short/refund indications, counting sales
module vend_core #(
    parameter int                           N_ITEMS    = 2,
    parameter int                           N_COINS    = 3,
    parameter int                           CREDIT_W   = 12,
    parameter logic [N_ITEMS*CREDIT_W-1:0]  PRICES     = {12'd25, 12'd15},
    parameter logic [N_COINS*CREDIT_W-1:0]  COIN_VALS  = {12'd50, 12'd10, 12'd5},
    parameter int                           MAX_CREDIT = 999,
    parameter int                           HOLD_CYC   = 120_000_000,
    parameter int                           SOLD_W     = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_COINS-1:0]          coin_stb,
    input  logic [N_ITEMS-1:0]          buy_stb,
    input  logic                        refund_stb,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        out_take,
    output logic [N_ITEMS-1:0]          vend_item,
    output logic                        out_less,
    output logic                        out_money,
    output logic [CREDIT_W-1:0]         change_amt,
    output logic                        coin_reject,
    output logic [N_ITEMS*SOLD_W-1:0]   sold_cnt
);
    localparam int                  TW        = $clog2(HOLD_CYC + 1);
    localparam logic [TW-1:0]       HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {IDLE, VEND, LESS, REFUND} state_t;

    state_t                     state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [CREDIT_W-1:0]        credit_q, credit_d;
    logic                       take_q, take_d;
    logic [N_ITEMS-1:0]         item_q, item_d;
    logic                       less_q, less_d;
    logic                       money_q, money_d;
    logic [CREDIT_W-1:0]        chg_q, chg_d;
    logic                       rej_q, rej_d;
    logic [N_ITEMS*SOLD_W-1:0]  sold_q, sold_d;

    logic                       coin_hit;
    logic [CREDIT_W-1:0]        coin_val;
    logic [CREDIT_W:0]          coin_sum;
    logic                       coin_ok;
    logic [CREDIT_W-1:0]        credit_c;
    logic [N_ITEMS-1:0]         buy_oh;
    logic [CREDIT_W-1:0]        buy_price;
    logic                       afford;

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok  = coin_hit && (state_q != REFUND) && (coin_sum <= MAX_C);
    assign credit_c = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    assign buy_oh   = buy_stb & (~buy_stb + N_ITEMS'(1));
    assign afford   = {1'b0, credit_q} >= {1'b0, buy_price};

    // pick the lowest-index coin and the price of the lowest-index requested item
    always_comb begin
        coin_hit  = 1'b0;
        coin_val  = '0;
        buy_price = '0;
        for (int j = N_COINS - 1; j >= 0; j--) begin
            if (coin_stb[j]) begin
                coin_hit = 1'b1;
                coin_val = COIN_VALS[j*CREDIT_W +: CREDIT_W];
            end
        end
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (buy_stb[i]) buy_price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    // next-state, credit, indicator and sales-counter logic
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        credit_d = credit_c;
        take_d   = take_q;
        item_d   = item_q;
        less_d   = less_q;
        money_d  = money_q;
        chg_d    = chg_q;
        rej_d    = coin_hit && !coin_ok;
        sold_d   = sold_q;
        if (state_q == IDLE) begin
            if (refund_stb && credit_q != '0) begin
                chg_d    = credit_q;
                credit_d = coin_ok ? coin_val : '0;
                money_d  = 1'b1;
                state_d  = REFUND;
            end else if (buy_stb != '0) begin
                if (afford) begin
                    credit_d = CREDIT_W'({1'b0, credit_c} - {1'b0, buy_price});
                    take_d   = 1'b1;
                    item_d   = buy_oh;
                    state_d  = VEND;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (buy_oh[i] && sold_q[i*SOLD_W +: SOLD_W] != '1)
                            sold_d[i*SOLD_W +: SOLD_W] = sold_q[i*SOLD_W +: SOLD_W] + SOLD_W'(1);
                    end
                end else begin
                    less_d  = 1'b1;
                    state_d = LESS;
                end
            end
        end else if (timer_q == HOLD_LAST) begin
            state_d = IDLE;
            take_d  = 1'b0;
            item_d  = '0;
            less_d  = 1'b0;
            money_d = 1'b0;
            chg_d   = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // state and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            credit_q <= '0;
            take_q   <= 1'b0;
            item_q   <= '0;
            less_q   <= 1'b0;
            money_q  <= 1'b0;
            chg_q    <= '0;
            rej_q    <= 1'b0;
            sold_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            credit_q <= credit_d;
            take_q   <= take_d;
            item_q   <= item_d;
            less_q   <= less_d;
            money_q  <= money_d;
            chg_q    <= chg_d;
            rej_q    <= rej_d;
            sold_q   <= sold_d;
        end
    end

    assign credit      = credit_q;
    assign out_take    = take_q;
    assign vend_item   = item_q;
    assign out_less    = less_q;
    assign out_money   = money_q;
    assign change_amt  = chg_q;
    assign coin_reject = rej_q;
    assign sold_cnt    = sold_q;
endmodule

// File: tb/tb_vend_core.sv
// tb_vend_core: scoreboard bench for vend_core with directed coin/buy/refund vectors
module tb_vend_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  coin_stb = '0;
    logic [1:0]  buy_stb = '0;
    logic        refund_stb = 1'b0;
    logic [11:0] credit;
    logic        out_take;
    logic [1:0]  vend_item;
    logic        out_less;
    logic        out_money;
    logic [11:0] change_amt;
    logic        coin_reject;
    logic [11:0] sold_cnt;

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];
    logic p_take = 1'b0, p_less = 1'b0, p_money = 1'b0;

    always #5 clk = ~clk;

    vend_core #(
        .N_ITEMS(2), .N_COINS(3), .CREDIT_W(12),
        .PRICES({12'd25, 12'd15}), .COIN_VALS({12'd50, 12'd10, 12'd5}),
        .MAX_CREDIT(100), .HOLD_CYC(8), .SOLD_W(6)
    ) dut (
        .clk(clk), .reset(reset), .coin_stb(coin_stb), .buy_stb(buy_stb),
        .refund_stb(refund_stb), .credit(credit), .out_take(out_take),
        .vend_item(vend_item), .out_less(out_less), .out_money(out_money),
        .change_amt(change_amt), .coin_reject(coin_reject), .sold_cnt(sold_cnt)
    );

    function automatic logic [29:0] ev(input logic t, input logic l, input logic m, input logic r,
                                       input logic [1:0] it, input logic [11:0] chg, input logic [11:0] cr);
        return {t, l, m, r, it, chg, cr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: whenever an indication rises or a coin is rejected, compare against the next expected event
    always @(negedge clk) begin
        if (!reset && ((out_take && !p_take) || (out_less && !p_less) || (out_money && !p_money) || coin_reject)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %0h expected none",
                         {out_take, out_less, out_money, coin_reject, vend_item, change_amt, credit});
            end else begin
                chk("event", 32'({out_take, out_less, out_money, coin_reject, vend_item, change_amt, credit}),
                    32'(exp_q.pop_front()));
            end
        end
        p_take  = out_take;
        p_less  = out_less;
        p_money = out_money;
    end

    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic r,
                         input bit push, input logic [29:0] e);
        @(negedge clk);
        coin_stb = c;
        buy_stb = b;
        refund_stb = r;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        coin_stb = '0;
        buy_stb = '0;
        refund_stb = 1'b0;
    endtask

    task automatic coin(input int j, input logic [11:0] cr);
        drive(3'(1 << j), 2'b00, 1'b0, 1'b0, '0);
        chk("credit_after_coin", 32'(credit), 32'(cr));
    endtask

    task automatic wait_idle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({out_take, out_less, out_money, coin_reject, vend_item}), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sold", 32'(sold_cnt), 32'd0);

        coin(1, 12'd10);
        coin(0, 12'd15);
        drive(3'b000, 2'b01, 1'b0, 1'b1, ev(1, 0, 0, 0, 2'b01, 12'd0, 12'd0));
        repeat (7) @(negedge clk);
        chk("vend_hold_last", 32'({out_take, vend_item}), 32'b101);
        @(negedge clk);
        chk("vend_hold_end", 32'({out_take, vend_item}), 32'b000);
        chk("sold_after_vend", 32'(sold_cnt), 32'd1);

        coin(1, 12'd10);
        coin(1, 12'd20);
        drive(3'b000, 2'b10, 1'b0, 1'b1, ev(0, 1, 0, 0, 2'b00, 12'd0, 12'd20));
        drive(3'b000, 2'b01, 1'b0, 1'b0, '0);
        repeat (5) @(negedge clk);
        chk("less_hold_last", 32'({out_less, out_take, credit}), 32'({1'b1, 1'b0, 12'd20}));
        @(negedge clk);
        chk("less_hold_end", 32'({out_less, out_take, credit}), 32'({1'b0, 1'b0, 12'd20}));

        coin(1, 12'd30);
        coin(1, 12'd40);
        coin(1, 12'd50);
        coin(1, 12'd60);
        drive(3'b000, 2'b00, 1'b1, 1'b1, ev(0, 0, 1, 0, 2'b00, 12'd60, 12'd0));
        drive(3'b001, 2'b00, 1'b0, 1'b1, ev(0, 0, 1, 1, 2'b00, 12'd60, 12'd0));
        repeat (5) @(negedge clk);
        chk("refund_hold_last", 32'({out_money, change_amt}), 32'({1'b1, 12'd60}));
        @(negedge clk);
        chk("refund_hold_end", 32'({out_money, change_amt, credit}), 32'd0);

        coin(2, 12'd50);
        coin(1, 12'd60);
        coin(1, 12'd70);
        coin(1, 12'd80);
        coin(1, 12'd90);
        drive(3'b100, 2'b00, 1'b0, 1'b1, ev(0, 0, 0, 1, 2'b00, 12'd0, 12'd90));
        coin(1, 12'd100);
        drive(3'b001, 2'b00, 1'b0, 1'b1, ev(0, 0, 0, 1, 2'b00, 12'd0, 12'd100));
        drive(3'b000, 2'b00, 1'b1, 1'b1, ev(0, 0, 1, 0, 2'b00, 12'd100, 12'd0));
        wait_idle();

        for (int k = 1; k <= 4; k++) coin(1, 12'(10 * k));
        drive(3'b000, 2'b11, 1'b1, 1'b1, ev(0, 0, 1, 0, 2'b00, 12'd40, 12'd0));
        wait_idle();
        chk("sold_after_refund", 32'(sold_cnt), 32'd1);
        for (int k = 1; k <= 4; k++) coin(1, 12'(10 * k));
        drive(3'b000, 2'b11, 1'b0, 1'b1, ev(1, 0, 0, 0, 2'b01, 12'd0, 12'd25));
        chk("sold_two", 32'(sold_cnt), 32'd2);

        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midvend_reset_out", 32'({out_take, vend_item, out_less, out_money}), 32'd0);
        chk("midvend_reset_credit", 32'(credit), 32'd0);
        chk("midvend_reset_sold", 32'(sold_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 64; k++) begin
            coin(1, 12'd10);
            coin(0, 12'd15);
            drive(3'b000, 2'b01, 1'b0, 1'b1, ev(1, 0, 0, 0, 2'b01, 12'd0, 12'd0));
            wait_idle();
        end
        chk("sold_saturate", 32'(sold_cnt), 32'd63);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_core.md
Name: vend_core

Overview:
Parametrised vending-machine transaction core. Consumes debounced, single-cycle coin, buy and refund strobes, tracks credit, and issues vend, short-credit and refund indications for a configurable item count. Each indication is held for a programmable time. It sits between the key debouncers and the seven-segment display driver, and exports credit and per-item sales counts. It adds change/refund return, credit saturation and coin rejection.

Parameters:
N_ITEMS, 2, number of selectable items (1..8)
N_COINS, 3, number of coin inputs (1..4)
CREDIT_W, 12, credit/price width in units of 0.1 yuan
PRICES, {12'd25,12'd15}, packed N_ITEMS*CREDIT_W; item i price at [i*CREDIT_W +: CREDIT_W]
COIN_VALS, {12'd50,12'd10,12'd5}, packed N_COINS*CREDIT_W; coin j value likewise
MAX_CREDIT, 999, credit ceiling (must be less than 2**CREDIT_W)
HOLD_CYC, 120_000_000, clk cycles each indication is held (3 s at 40 MHz)
SOLD_W, 6, per-item sales counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
coin_stb  in  N_COINS  one-cycle coin-inserted strobes, bit j = coin j
buy_stb  in  N_ITEMS  one-cycle purchase-request strobes
refund_stb  in  1  one-cycle refund request
credit  out  CREDIT_W  current credit
out_take  out  1  item-dispensed indicator
vend_item  out  N_ITEMS  one-hot item being dispensed, valid while out_take=1
out_less  out  1  insufficient-credit indicator
out_money  out  1  refund-in-progress indicator
change_amt  out  CREDIT_W  amount returned, valid while out_money=1
coin_reject  out  1  one-cycle pulse when a coin is refused
sold_cnt  out  N_ITEMS*SOLD_W  packed per-item sales counters

Behaviour:
- Reset (async) clears all outputs, credit, counters and hold timer, and forces IDLE. Each sync output register is 0 at reset.
- States: IDLE, VEND, LESS, REFUND. All transitions occur on the clk rising edge. Outputs are registered and change 1 cycle after the causing strobe.
- Coin handling, all states except REFUND:
  - Multiple coin bits in one cycle: only the lowest index is taken.
  - If credit + value > MAX_CREDIT, the coin is refused: coin_reject pulses 1 cycle and credit is unchanged.
  - In REFUND, any coin is refused with coin_reject.
- IDLE priority order: refund_stb, then buy_stb, then idle.
  - refund_stb with credit > 0: change_amt <= credit, credit <= 0, out_money <= 1, go to REFUND.
  - refund_stb with credit = 0: ignored.
  - buy_stb: the lowest set index i wins.
    - If credit >= price_i: credit <= credit - price_i (plus any accepted coin in the same cycle); vend_item[i] <= 1; out_take <= 1; sold_cnt[i] increments, saturating at all-ones; go to VEND.
    - Otherwise: out_less <= 1, credit unchanged, go to LESS.
  - The buy decision compares against pre-coin credit. A coin in the same cycle still adds.
- VEND/LESS/REFUND: the hold timer runs for HOLD_CYC cycles, starting at 0 on entry. When it reaches HOLD_CYC-1, the indicator, vend_item and change_amt clear next cycle and the state returns to IDLE.
- buy_stb and refund_stb outside IDLE are ignored and not queued.
- Strobes arriving on the exact cycle of return to IDLE are evaluated against IDLE rules on that cycle.
- Credit never underflows or exceeds MAX_CREDIT. All arithmetic is at CREDIT_W+1 bits internally before compare.
- Reset mid-hold: indicators drop immediately (async) and credit is lost. A refund in progress is not completed.

Test Plan:
- Reset, then coins 10,5 (stb bits 1,0 on separate cycles) -> credit 15. buy_stb=01 -> out_take=1, vend_item=01, credit 0, sold_cnt[0]=1. Hold HOLD_CYC (set to 8 in sim) cycles -> IDLE.
- credit 20, buy_stb=10 -> out_less=1 for 8 cycles, credit stays 20. buy_stb during hold -> ignored.
- credit 60, refund_stb -> out_money=1, change_amt=60, credit 0. coin 5 during REFUND -> coin_reject pulse, credit 0.
- MAX_CREDIT=100: coins to 90, then coin 50 -> coin_reject, credit 90. Then coin 10 -> credit 100.
- Simultaneous buy_stb=11 and refund_stb with credit 40 -> refund wins: change_amt 40, no vend. Next test: buy_stb=11 alone -> item 0 vended, credit 25.
- Assert reset mid-VEND -> out_take, vend_item and credit are 0 immediately. sold_cnt clears. Saturation check: 64 vends of item 0 with SOLD_W=6 -> sold_cnt[0] holds 63.
